// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings, grant ids and default widths for the memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_t;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_MAX_DATA_BURST = 4;
    localparam int DEF_TIMEOUT        = 16;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave is the arbiter, master the environment.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic [DATA_WIDTH-1:0] if_rdata_o;
    logic                  if_ack_o;

    logic                  dm_req_i;
    logic                  dm_we_i;
    logic [ADDR_WIDTH-1:0] dm_addr_i;
    logic [DATA_WIDTH-1:0] dm_wdata_i;
    logic [DATA_WIDTH-1:0] dm_rdata_o;
    logic                  dm_ack_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_ack_i;

    logic                  stall_o;
    logic                  err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ack_i,
        output if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ack_i,
        input  if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o, err_o
    );

endinterface

// File: rtl/arb_watchdog.sv
// Purpose: counts cycles of an outstanding memory access and flags expiry.
// Latency: expire is combinational on the cycle the count reaches TIMEOUT-1.
// Backpressure: none; TIMEOUT = 0 ties expire low.
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CW = cnt_width(TIMEOUT);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, reset, en, clr};
            assign expire    = 1'b0;
        end else begin : g_on
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else if (clr) begin
                    cnt_q <= '0;
                end else if (en) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign expire = en && (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port memory between fetch (read-only) and data (load/store).
// Latency: grant to ack = memory latency + 2 cycles; one access in flight, no back-to-back grants.
// Backpressure: requests are levels held until ack; stall_o is high while any request is unacked.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int MAX_DATA_BURST = DEF_MAX_DATA_BURST,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int            BW        = cnt_width(MAX_DATA_BURST);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

    state_t                state_q, state_d;
    gnt_t                  gnt_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] dm_rdata_q;
    logic                  abort_q;
    logic [BW-1:0]         burst_q;

    logic                  grant_vld;
    logic                  grant_dm;
    logic                  mem_req;
    logic                  resp;
    logic                  expire;

    // Data wins contested arbitration until it has used its burst allowance.
    assign grant_vld = (state_q == IDLE) && (bus.if_req_i || bus.dm_req_i);
    assign grant_dm  = bus.dm_req_i && !(bus.if_req_i && (burst_q == BURST_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        resp    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.if_req_i || bus.dm_req_i) state_d = BUSY;
            end
            BUSY: begin
                mem_req = 1'b1;
                if (bus.mem_ack_i || expire) state_d = RESP;
            end
            RESP: begin
                resp    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .en     (mem_req),
        .clr    (!mem_req),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q      <= GNT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            abort_q    <= 1'b0;
            burst_q    <= '0;
        end else begin
            if (grant_vld) begin
                gnt_q   <= grant_dm ? GNT_DM : GNT_IF;
                addr_q  <= grant_dm ? bus.dm_addr_i : bus.if_addr_i;
                we_q    <= grant_dm && bus.dm_we_i;
                wdata_q <= grant_dm ? bus.dm_wdata_i : '0;
                abort_q <= 1'b0;
                if (!grant_dm) begin
                    burst_q <= '0;
                end else if (bus.if_req_i && (burst_q != BURST_MAX)) begin
                    burst_q <= burst_q + 1'b1;
                end
            end
            // A late ack on the expiry cycle still completes normally.
            if (mem_req && bus.mem_ack_i) begin
                if (gnt_q == GNT_IF) if_rdata_q <= bus.mem_rdata_i;
                else                 dm_rdata_q <= we_q ? '0 : bus.mem_rdata_i;
            end else if (mem_req && expire) begin
                if (gnt_q == GNT_IF) if_rdata_q <= '0;
                else                 dm_rdata_q <= '0;
                abort_q <= 1'b1;
            end
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_req && we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

    assign bus.if_ack_o    = resp && (gnt_q == GNT_IF);
    assign bus.dm_ack_o    = resp && (gnt_q == GNT_DM);
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.err_o       = resp && abort_q;

    assign bus.stall_o     = (bus.if_req_i && !bus.if_ack_o) || (bus.dm_req_i && !bus.dm_ack_o);

endmodule
